// File: rtl/ef_adc_sar_pkg.sv
// Shared types and constants for the SAR ADC controller.
// Consumed by ef_adc_sar_reg and ef_adc_sar_ctrl.
package ef_adc_sar_pkg;

  localparam int ADC_DATA_W = 10;
  localparam int ADC_CH_W   = 3;

  localparam logic [ADC_DATA_W-1:0] SAR_MSB_INIT = 10'h200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_e;

endpackage

// File: rtl/ef_adc_sar_reg.sv
// Successive-approximation register: trial code plus one-hot bit-index shifter.
// init loads the MSB trial; each step keeps or clears the current bit and sets the next one.
module ef_adc_sar_reg
  import ef_adc_sar_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              init,
  input  logic              step,
  input  logic              cmp,
  output logic [DATA_W-1:0] code,
  output logic              last
);

  logic [DATA_W-1:0] r_code;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] w_code_nxt;

  // Bit under test is r_mask; the next-lower trial bit is raised in the same edge.
  assign w_code_nxt = (cmp ? r_code : (r_code & ~r_mask)) | (r_mask >> 1);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_code <= '0;
      r_mask <= '0;
    end else if (init) begin
      r_code <= DATA_W'(SAR_MSB_INIT);
      r_mask <= DATA_W'(SAR_MSB_INIT);
    end else if (step) begin
      r_code <= w_code_nxt;
      r_mask <= r_mask >> 1;
    end
  end

  assign code = r_code;
  assign last = r_mask[0];

endmodule

// File: rtl/ef_adc_sar_ctrl.sv
// Sequencing controller for the 10-bit, 8-channel SAR ADC macro.
// Optional channel scan is built when EF_ADC_SAR_CTRL_SCAN_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for en_i && start_i; EN follows en_i
//   SAMPLE  | macro tracking input, down-counter running
//   CONVERT | HOLD high, one bit resolved per clock
//   DONE    | one-cycle eoc_o, result_o valid
module ef_adc_sar_ctrl
  import ef_adc_sar_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int CH_W   = ADC_CH_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              en_i,
  input  logic              start_i,
  input  logic [CH_W-1:0]   chan_i,
  input  logic [7:0]        sample_cycles_i,
  input  logic              cmp_i,
`ifdef EF_ADC_SAR_CTRL_SCAN_EN
  input  logic [CH_W-1:0]   scan_last_i,
`endif
  output logic              adc_en_o,
  output logic              adc_hold_o,
  output logic [CH_W-1:0]   adc_sel_o,
  output logic [DATA_W-1:0] dac_o,
  output logic [DATA_W-1:0] result_o,
  output logic [CH_W-1:0]   chan_o,
  output logic              eoc_o,
  output logic              busy_o
);

  sar_state_e        r_state;
  sar_state_e        w_state_nxt;
  logic [7:0]        r_cnt;
  logic [CH_W-1:0]   r_sel;
  logic [DATA_W-1:0] r_result;
  logic [CH_W-1:0]   r_chan;

  logic [7:0]        w_s_eff;
  logic              w_accept;
  logic              w_cnt_tc;
  logic              w_scan_more;
  logic              w_sar_init;
  logic              w_sar_step;
  logic [DATA_W-1:0] w_code;
  logic              w_last;

  assign w_s_eff  = (sample_cycles_i == 8'd0) ? 8'd1 : sample_cycles_i;
  assign w_accept = (r_state == ST_IDLE) && en_i && start_i;
  assign w_cnt_tc = (r_cnt == 8'd1);

`ifdef EF_ADC_SAR_CTRL_SCAN_EN
  // Sample length is frozen at start so mid-scan edits only affect the next start.
  logic [7:0] r_s_lat;

  assign w_scan_more = (r_sel < scan_last_i);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_s_lat <= 8'd0;
    end else if (w_accept) begin
      r_s_lat <= w_s_eff;
    end
  end
`else
  assign w_scan_more = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sar_init  = 1'b0;
    w_sar_step  = 1'b0;
    if (!en_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) w_state_nxt = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (w_cnt_tc) begin
            w_state_nxt = ST_CONVERT;
            w_sar_init  = 1'b1;
          end
        end
        ST_CONVERT: begin
          w_sar_step = 1'b1;
          if (w_last) w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          w_state_nxt = w_scan_more ? ST_SAMPLE : ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_cnt    <= 8'd0;
      r_sel    <= '0;
      r_result <= '0;
      r_chan   <= '0;
    end else if (w_accept) begin
      r_sel <= chan_i;
      r_cnt <= w_s_eff;
    end else if (en_i) begin
      case (r_state)
        ST_SAMPLE: begin
          if (!w_cnt_tc) r_cnt <= r_cnt - 8'd1;
        end
        ST_CONVERT: begin
          // At the last step the trial bit 0 is set, so cmp_i alone decides it.
          if (w_last) begin
            r_result <= {w_code[DATA_W-1:1], cmp_i};
            r_chan   <= r_sel;
          end
        end
        ST_DONE: begin
`ifdef EF_ADC_SAR_CTRL_SCAN_EN
          if (w_scan_more) begin
            r_sel <= r_sel + 1'b1;
            r_cnt <= r_s_lat;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  ef_adc_sar_reg #(
    .DATA_W (DATA_W)
  ) u_sar (
    .clk  (clk),
    .RST  (RST),
    .init (w_sar_init),
    .step (w_sar_step),
    .cmp  (cmp_i),
    .code (w_code),
    .last (w_last)
  );

  // RST gates EN so the macro is disabled the instant reset asserts.
  assign adc_en_o   = RST & ((r_state == ST_IDLE) ? en_i : 1'b1);
  assign adc_hold_o = (r_state == ST_CONVERT);
  assign dac_o      = (r_state == ST_CONVERT) ? w_code : '0;
  assign adc_sel_o  = r_sel;
  assign result_o   = r_result;
  assign chan_o     = r_chan;
  assign eoc_o      = (r_state == ST_DONE);
  assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ef_adc_sar_ctrl.sv
// Self-checking bench for ef_adc_sar_ctrl: random conversions against a comparator/result model.
// Scan checks are compiled when EF_ADC_SAR_CTRL_SCAN_EN is defined.
module tb_ef_adc_sar_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic       en_i;
  logic       start_i;
  logic [2:0] chan_i;
  logic [7:0] sample_cycles_i;
  logic       cmp_i;
`ifdef EF_ADC_SAR_CTRL_SCAN_EN
  logic [2:0] scan_last_i;
`endif
  logic       adc_en_o;
  logic       adc_hold_o;
  logic [2:0] adc_sel_o;
  logic [9:0] dac_o;
  logic [9:0] result_o;
  logic [2:0] chan_o;
  logic       eoc_o;
  logic       busy_o;

  logic [9:0] tgt_r;
  logic [9:0] exp_result;
  logic [2:0] exp_chan;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Ideal macro comparator: trial at or below the input voltage keeps the bit.
  assign cmp_i = (dac_o <= tgt_r);

  ef_adc_sar_ctrl dut (
    .clk             (clk),
    .RST             (RST),
    .en_i            (en_i),
    .start_i         (start_i),
    .chan_i          (chan_i),
    .sample_cycles_i (sample_cycles_i),
    .cmp_i           (cmp_i),
`ifdef EF_ADC_SAR_CTRL_SCAN_EN
    .scan_last_i     (scan_last_i),
`endif
    .adc_en_o        (adc_en_o),
    .adc_hold_o      (adc_hold_o),
    .adc_sel_o       (adc_sel_o),
    .dac_o           (dac_o),
    .result_o        (result_o),
    .chan_o          (chan_o),
    .eoc_o           (eoc_o),
    .busy_o          (busy_o)
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Binary search from the MSB: k-th trial = target bits above the test bit, plus the test bit.
  function automatic int unsigned trial_code(input int unsigned tgt, input int k);
    int b;
    b = 9 - k;
    return (tgt & ~((32'd1 << (b + 1)) - 1)) | (32'd1 << b);
  endfunction

  // One conversion; latency counted in edges after the accepting edge (cycle n spans edge n-1..n).
  task automatic run_conv(input int unsigned ch, input int unsigned sc, input int unsigned tgt,
                          input bit poke_start);
    int unsigned s;
    int n, k;
    bit seen;
    s = (sc == 0) ? 1 : sc;
    tgt_r = tgt[9:0];
    @(negedge clk);
    start_i = 1'b1;
    chan_i = ch[2:0];
    sample_cycles_i = sc[7:0];
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chan_i = 3'($urandom);
    sample_cycles_i = 8'($urandom_range(0, 20));
    check_eq("busy_after_start", busy_o, 1);
    n = 0;
    k = 0;
    seen = 1'b0;
    while (!seen && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      start_i = (poke_start && k == 3);
      if (adc_hold_o) begin
        if (k < 10) check_eq("dac_trial", dac_o, trial_code(tgt, k));
        check_eq("sel_stable", adc_sel_o, ch);
        k++;
      end
      if (eoc_o) begin
        seen = 1'b1;
        check_eq("done_hold", adc_hold_o, 0);
        check_eq("done_dac", dac_o, 0);
      end
    end
    start_i = 1'b0;
    exp_result = tgt[9:0];
    exp_chan = ch[2:0];
    check_eq("eoc_seen", seen, 1);
    check_eq("eoc_latency", n, s + 10);
    check_eq("convert_cycles", k, 10);
    check_eq("result", result_o, exp_result);
    check_eq("chan_tag", chan_o, exp_chan);
    @(posedge clk);
    #1;
    check_eq("eoc_one_cycle", eoc_o, 0);
    check_eq("idle_after_done", busy_o, 0);
  endtask

  task automatic en_drop_test(input int unsigned ch, input int unsigned tgt);
    int n, k;
    bit eoc_hit;
    tgt_r = tgt[9:0];
    @(negedge clk);
    start_i = 1'b1;
    chan_i = ch[2:0];
    sample_cycles_i = 8'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    n = 0;
    k = 0;
    while (k < 5 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (adc_hold_o) k++;
    end
    check_eq("en_drop_reached_convert5", k, 5);
    en_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq("en_drop_busy", busy_o, 0);
    check_eq("en_drop_hold", adc_hold_o, 0);
    check_eq("en_drop_dac", dac_o, 0);
    check_eq("en_drop_adc_en", adc_en_o, 0);
    eoc_hit = eoc_o;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      eoc_hit |= eoc_o;
    end
    check_eq("en_drop_no_eoc", eoc_hit, 0);
    check_eq("en_drop_result_kept", result_o, exp_result);
    check_eq("en_drop_chan_kept", chan_o, exp_chan);
    en_i = 1'b1;
    #1;
    check_eq("idle_adc_en_follows", adc_en_o, 1);
  endtask

  task automatic reset_mid_sample_test();
    tgt_r = 10'h1C3;
    @(negedge clk);
    start_i = 1'b1;
    chan_i = 3'd6;
    sample_cycles_i = 8'd8;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    RST = 1'b0;
    #1;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_adc_en", adc_en_o, 0);
    check_eq("rst_sel", adc_sel_o, 0);
    check_eq("rst_hold", adc_hold_o, 0);
    check_eq("rst_dac", dac_o, 0);
    check_eq("rst_result", result_o, 0);
    check_eq("rst_chan", chan_o, 0);
    check_eq("rst_eoc", eoc_o, 0);
    exp_result = 10'd0;
    exp_chan = 3'd0;
    @(negedge clk);
    RST = 1'b1;
  endtask

`ifdef EF_ADC_SAR_CTRL_SCAN_EN
  task automatic scan_test(input int unsigned first, input int unsigned last_ch,
                           input int unsigned exp_pulses);
    int pulses, n;
    tgt_r = 10'h155;
    scan_last_i = last_ch[2:0];
    @(negedge clk);
    start_i = 1'b1;
    chan_i = first[2:0];
    sample_cycles_i = 8'd2;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    pulses = 0;
    n = 0;
    while (busy_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (eoc_o) begin
        check_eq("scan_tag", chan_o, first + pulses);
        check_eq("scan_result", result_o, 10'h155);
        pulses++;
      end
    end
    check_eq("scan_pulses", pulses, exp_pulses);
    check_eq("scan_idle", busy_o, 0);
    scan_last_i = 3'd0;
    exp_result = 10'h155;
    exp_chan = 3'(first + exp_pulses - 1);
  endtask
`endif

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0;
    en_i = 1'b0;
    start_i = 1'b0;
    chan_i = 3'd0;
    sample_cycles_i = 8'd0;
    tgt_r = 10'd0;
    exp_result = 10'd0;
    exp_chan = 3'd0;
`ifdef EF_ADC_SAR_CTRL_SCAN_EN
    scan_last_i = 3'd0;
`endif
    #3;
    en_i = 1'b1;
    #1;
    check_eq("reset_adc_en", adc_en_o, 0);
    check_eq("reset_hold", adc_hold_o, 0);
    check_eq("reset_eoc", eoc_o, 0);
    check_eq("reset_busy", busy_o, 0);
    check_eq("reset_sel", adc_sel_o, 0);
    check_eq("reset_dac", dac_o, 0);
    check_eq("reset_result", result_o, 0);
    check_eq("reset_chan", chan_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    #1;
    check_eq("idle_adc_en", adc_en_o, 1);

    run_conv(5, 4, 10'h2A5, 1'b0);
    run_conv(2, 3, 10'h000, 1'b0);
    run_conv(7, 1, 10'h3FF, 1'b0);
    run_conv(1, 0, 10'h0F0, 1'b0);
    run_conv(3, 5, 10'h1A7, 1'b1);

    for (int i = 0; i < 10; i++) begin
      run_conv($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 1023), i[0]);
    end

    en_drop_test(4, 10'h2C3);
    reset_mid_sample_test();
    run_conv(6, 2, 10'h31B, 1'b0);

`ifdef EF_ADC_SAR_CTRL_SCAN_EN
    scan_test(0, 3, 4);
    scan_test(6, 2, 1);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
